// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port RAM between a CPU port (0)
// and an IO/loader port (1). A granted request is latched, the RAM strobes are
// sequenced from the latched copy, and the winner gets a one-cycle ack with data.
//
// state  | meaning
// IDLE   | waiting for req0/req1; arbitrates and latches the winner
// BUSY   | driving RAM strobes (one write cycle or RD_LAT read cycles)
// RESP   | ack pulse to the granted port, rdata valid for reads
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    input  logic [DW-1:0] mem_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_RD_LAST = 4'(RD_LAT - 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_rr;      // port preferred when both request
    logic            r_g;       // granted port
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic [3:0]      r_cnt;

    logic            w_any_req;
    logic            w_win;
    logic            w_rd_done;
    logic            w_in_busy;
    logic            w_in_resp;

    assign w_any_req = req0 | req1;
    // Contention goes to the preferred port; otherwise the lone requester wins.
    assign w_win     = (req0 & req1) ? r_rr : req1;
    assign w_rd_done = (r_cnt == LP_RD_LAST);
    assign w_in_busy = (r_state == S_BUSY);
    assign w_in_resp = (r_state == S_RESP);

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_BUSY;
            S_BUSY:  if (r_we || w_rd_done) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, read-latency counter, read capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr    <= 1'b0;
            r_g     <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_g     <= w_win;
                        r_we    <= w_win ? we1    : we0;
                        r_addr  <= w_win ? addr1  : addr0;
                        r_wdata <= w_win ? wdata1 : wdata0;
                        r_rdata <= '0;   // writes return zero data
                        r_cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    if (!r_we) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_rd_done) r_rdata <= mem_data;
                    end
                end
                S_RESP: r_rr <= ~r_g;
                default: ;
            endcase
        end
    end

    // RAM strobes and acks decoded from state; all idle at zero.
    always_comb begin
        mem_we   = w_in_busy & r_we;
        mem_re   = w_in_busy & ~r_we;
        mem_addr = w_in_busy ? r_addr  : '0;
        mem_di   = w_in_busy ? r_wdata : '0;
        ack0     = w_in_resp & ~r_g;
        ack1     = w_in_resp & r_g;
        rdata0   = ack0 ? r_rdata : '0;
        rdata1   = ack1 ? r_rdata : '0;
        busy     = (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT=1 as index 0, RD_LAT=3 as index 1),
// each with its own small RAM. Directed tasks cover the listed scenarios; a random
// task compares against a transaction-level timing/data model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0 [2];
    logic        we0  [2];
    logic [31:0] addr0 [2];
    logic [31:0] wdata0 [2];
    logic        req1 [2];
    logic        we1  [2];
    logic [31:0] addr1 [2];
    logic [31:0] wdata1 [2];
    logic        ack0 [2];
    logic        ack1 [2];
    logic [31:0] rdata0 [2];
    logic [31:0] rdata1 [2];
    logic        mem_re [2];
    logic        mem_we [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_di [2];
    logic [31:0] mem_data [2];
    logic        busy [2];

    logic [31:0] ram0 [16];
    logic [31:0] ram1 [16];
    logic        ram_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .ack0(ack0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .ack1(ack1[0]), .rdata1(rdata1[0]),
        .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_di(mem_di[0]), .mem_data(mem_data[0]), .busy(busy[0])
    );

    mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .ack0(ack0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .ack1(ack1[1]), .rdata1(rdata1[1]),
        .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_di(mem_di[1]), .mem_data(mem_data[1]), .busy(busy[1])
    );

    assign mem_data[0] = mem_re[0] ? ram0[mem_addr[0][3:0]] : 32'h0;
    assign mem_data[1] = mem_re[1] ? ram1[mem_addr[1][3:0]] : 32'h0;

    always @(posedge clk) begin
        if (ram_clr) for (int i = 0; i < 16; i++) ram0[i] <= 32'h0;
        else if (mem_we[0]) ram0[mem_addr[0][3:0]] <= mem_di[0];
    end

    always @(posedge clk) begin
        if (ram_clr) for (int i = 0; i < 16; i++) ram1[i] <= 32'h0;
        else if (mem_we[1]) ram1[mem_addr[1][3:0]] <= mem_di[1];
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic any_out(input int d);
        return ack0[d] | ack1[d] | mem_re[d] | mem_we[d] | busy[d] |
               (|rdata0[d]) | (|rdata1[d]) | (|mem_addr[d]) | (|mem_di[d]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            req0[d] = 0; we0[d] = 0; addr0[d] = 0; wdata0[d] = 0;
            req1[d] = 0; we1[d] = 0; addr1[d] = 0; wdata1[d] = 0;
        end
    endtask

    task automatic apply_reset();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic set_port(input int d, input int p, input logic rq, input logic w,
                            input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin req0[d] = rq; we0[d] = w; addr0[d] = a; wdata0[d] = wd; end
        else        begin req1[d] = rq; we1[d] = w; addr1[d] = a; wdata1[d] = wd; end
    endtask

    // Drives one request (DUT assumed idle) and records what the RAM side and ack did.
    task automatic run_access(input int d, input int p, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, output int ack_cyc, output int we_cnt,
                              output int re_cnt, output logic [31:0] s_addr,
                              output logic [31:0] s_di, output logic [31:0] rd,
                              output int other_ack);
        logic a_ack;
        ack_cyc = -1; we_cnt = 0; re_cnt = 0; s_addr = 0; s_di = 0; rd = 0; other_ack = 0;
        set_port(d, p, 1'b1, w, a, wd);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (mem_we[d]) begin we_cnt++; s_addr = mem_addr[d]; s_di = mem_di[d]; end
            if (mem_re[d]) begin re_cnt++; s_addr = mem_addr[d]; end
            a_ack = (p == 0) ? ack0[d] : ack1[d];
            if (((p == 0) ? ack1[d] : ack0[d]) == 1'b1) other_ack++;
            if (a_ack) begin
                ack_cyc = c;
                rd = (p == 0) ? rdata0[d] : rdata1[d];
            end
            tick();
            if (a_ack) begin
                set_port(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
                break;
            end
        end
        set_port(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        idle_inputs();
        ram_clr = 1;
        rst = 0;
        tick();
        tick();
        ram_clr = 0;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (any_out(d) !== 1'b0) begin
                n_fail++; $display("FAIL reset_outputs dut%0d: got nonzero output, expected all 0", d);
            end
        end
        rst = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (any_out(d) !== 1'b0) begin
                    n_fail++; $display("FAIL idle_outputs dut%0d cycle %0d: busy=%b ack0=%b ack1=%b re=%b we=%b, expected all 0",
                                       d, c, busy[d], ack0[d], ack1[d], mem_re[d], mem_we[d]);
                end
            end
        end
        tick();
    endtask

    task automatic test_write();
        int ac, wc, rc, oa;
        logic [31:0] sa, sd, rd;
        run_access(0, 0, 1'b1, 32'h1, 32'h5A, ac, wc, rc, sa, sd, rd, oa);
        n_checks++;
        if (ac !== 2) begin n_fail++; $display("FAIL write_ack_latency: got %0d, expected 2", ac); end
        n_checks++;
        if (wc !== 1 || rc !== 0) begin
            n_fail++; $display("FAIL write_strobes: we cycles %0d re cycles %0d, expected 1 and 0", wc, rc);
        end
        n_checks++;
        if (sa !== 32'h1 || sd !== 32'h5A) begin
            n_fail++; $display("FAIL write_addr_data: addr %h di %h, expected 1 and 5a", sa, sd);
        end
        n_checks++;
        if (rd !== 32'h0 || oa !== 0) begin
            n_fail++; $display("FAIL write_rdata: rdata %h other acks %0d, expected 0 and 0", rd, oa);
        end
        // Load RAM[0]=0x37 through port 1 for the read test.
        run_access(0, 1, 1'b1, 32'h0, 32'h37, ac, wc, rc, sa, sd, rd, oa);
        n_checks++;
        if (ac !== 2 || wc !== 1 || sd !== 32'h37) begin
            n_fail++; $display("FAIL write_port1: ack cycle %0d we %0d di %h, expected 2 1 37", ac, wc, sd);
        end
    endtask

    task automatic test_read_lat1();
        int ac, wc, rc, oa;
        logic [31:0] sa, sd, rd;
        run_access(0, 0, 1'b0, 32'h0, 32'hDEAD, ac, wc, rc, sa, sd, rd, oa);
        n_checks++;
        if (ac !== 2) begin n_fail++; $display("FAIL read1_ack_latency: got %0d, expected 2", ac); end
        n_checks++;
        if (rc !== 1 || wc !== 0 || sa !== 32'h0) begin
            n_fail++; $display("FAIL read1_strobes: re %0d we %0d addr %h, expected 1 0 0", rc, wc, sa);
        end
        n_checks++;
        if (rd !== 32'h37) begin n_fail++; $display("FAIL read1_rdata: got %h, expected 37", rd); end
    endtask

    task automatic test_read_lat3();
        int ac, wc, rc, oa;
        logic [31:0] sa, sd, rd;
        run_access(1, 1, 1'b1, 32'h1, 32'h5A, ac, wc, rc, sa, sd, rd, oa);
        n_checks++;
        if (ac !== 2 || wc !== 1) begin
            n_fail++; $display("FAIL read3_preload: ack cycle %0d we %0d, expected 2 1", ac, wc);
        end
        run_access(1, 1, 1'b0, 32'h1, 32'h0, ac, wc, rc, sa, sd, rd, oa);
        n_checks++;
        if (ac !== 4) begin n_fail++; $display("FAIL read3_ack_latency: got %0d, expected 4", ac); end
        n_checks++;
        if (rc !== 3 || wc !== 0) begin
            n_fail++; $display("FAIL read3_re_cycles: re %0d we %0d, expected 3 0", rc, wc);
        end
        n_checks++;
        if (rd !== 32'h5A || oa !== 0) begin
            n_fail++; $display("FAIL read3_rdata: got %h other acks %0d, expected 5a 0", rd, oa);
        end
    endtask

    task automatic test_round_robin();
        int n_acks = 0;
        int port;
        idle_inputs();
        apply_reset();
        set_port(0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_port(0, 1, 1'b1, 1'b0, 32'h1, 32'h0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_checks++;
            if ((ack0[0] & ack1[0]) !== 1'b0) begin
                n_fail++; $display("FAIL rr_ack_overlap cycle %0d: both acks high, expected at most one", c);
            end
            if (ack0[0] | ack1[0]) begin
                port = ack1[0] ? 1 : 0;
                n_checks++;
                if (port !== (n_acks % 2) || c !== 2 + 3 * n_acks) begin
                    n_fail++; $display("FAIL rr_grant #%0d: port %0d at cycle %0d, expected port %0d at cycle %0d",
                                       n_acks, port, c, n_acks % 2, 2 + 3 * n_acks);
                end
                n_checks++;
                if ((port == 0 ? rdata0[0] : rdata1[0]) !== (port == 0 ? 32'h37 : 32'h5A)) begin
                    n_fail++; $display("FAIL rr_rdata #%0d: got %h, expected %h", n_acks,
                                       port == 0 ? rdata0[0] : rdata1[0], port == 0 ? 32'h37 : 32'h5A);
                end
                n_acks++;
            end
            tick();
        end
        n_checks++;
        if (n_acks !== 10) begin n_fail++; $display("FAIL rr_ack_count: got %0d, expected 10", n_acks); end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset_abort();
        idle_inputs();
        set_port(1, 1, 1'b1, 1'b0, 32'h1, 32'h0);
        tick();
        tick();
        n_checks++;
        if (busy[1] !== 1'b1 || mem_re[1] !== 1'b1) begin
            n_fail++; $display("FAIL abort_setup: busy %b re %b, expected 1 1", busy[1], mem_re[1]);
        end
        rst = 0;
        #1;
        n_checks++;
        if (any_out(1) !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs: busy %b re %b addr %h, expected all 0", busy[1], mem_re[1], mem_addr[1]);
        end
        idle_inputs();
        tick();
        rst = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (any_out(1) !== 1'b0) begin
                n_fail++; $display("FAIL abort_after cycle %0d: ack1 %b busy %b, expected 0 0", c, ack1[1], busy[1]);
            end
            tick();
        end
    endtask

    // Model: accesses are serialized; each grant occupies the RAM until its ack cycle,
    // and the next arbitration can happen the cycle after the ack.
    task automatic test_random(input int d);
        int          lt = (d == 0) ? 1 : 3;
        int          free_at = 0;
        int          exp_cyc = 0;
        int          exp_port = 0;
        int          w;
        bit          has_exp = 0;
        bit          rr = 0;
        bit          pend [2];
        bit          granted [2];
        bit          done [2];
        logic        gw;
        logic [31:0] ga, gd;
        logic [31:0] exp_rd = 0;
        logic [31:0] mm [16];
        logic        e_ack0, e_ack1;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; granted[p] = 0; done[p] = 0; end
        for (int i = 0; i < 16; i++) mm[i] = 32'h0;
        idle_inputs();
        ram_clr = 1;
        apply_reset();
        ram_clr = 0;
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (done[p]) begin
                    pend[p] = 0; done[p] = 0; granted[p] = 0;
                    set_port(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
                end
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    set_port(d, p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
                end else if (pend[p] && granted[p] && $urandom_range(0, 3) == 0) begin
                    set_port(d, p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
                end
            end
            if (!has_exp && k >= free_at && (pend[0] || pend[1])) begin
                w  = (pend[0] && pend[1]) ? int'(rr) : (pend[1] ? 1 : 0);
                rr = (w == 0);
                granted[w] = 1;
                gw = (w == 0) ? we0[d]    : we1[d];
                ga = (w == 0) ? addr0[d]  : addr1[d];
                gd = (w == 0) ? wdata0[d] : wdata1[d];
                if (gw) begin
                    exp_rd = 32'h0;
                    mm[ga[3:0]] = gd;
                    exp_cyc = k + 2;
                end else begin
                    exp_rd = mm[ga[3:0]];
                    exp_cyc = k + lt + 1;
                end
                exp_port = w;
                has_exp  = 1;
                free_at  = exp_cyc + 1;
            end
            @(negedge clk);
            e_ack0 = has_exp && exp_port == 0 && exp_cyc == k;
            e_ack1 = has_exp && exp_port == 1 && exp_cyc == k;
            n_checks++;
            if (ack0[d] !== e_ack0 || ack1[d] !== e_ack1) begin
                n_fail++; $display("FAIL rand_ack dut%0d cycle %0d: ack0 %b ack1 %b, expected %b %b",
                                   d, k, ack0[d], ack1[d], e_ack0, e_ack1);
            end
            n_checks++;
            if (rdata0[d] !== (e_ack0 ? exp_rd : 32'h0) || rdata1[d] !== (e_ack1 ? exp_rd : 32'h0)) begin
                n_fail++; $display("FAIL rand_rdata dut%0d cycle %0d: rdata0 %h rdata1 %h, expected %h on port %0d",
                                   d, k, rdata0[d], rdata1[d], exp_rd, exp_port);
            end
            n_checks++;
            if ((mem_re[d] & mem_we[d]) !== 1'b0) begin
                n_fail++; $display("FAIL rand_re_we dut%0d cycle %0d: re and we both high, expected exclusive", d, k);
            end
            if (e_ack0 || e_ack1) begin
                has_exp = 0;
                done[exp_port] = 1;
            end
            tick();
        end
        idle_inputs();
        repeat (6) tick();
    endtask

    initial begin
        rst = 0;
        ram_clr = 0;
        idle_inputs();
        test_reset();
        test_write();
        test_read_lat1();
        test_read_lat3();
        test_round_robin();
        test_reset_abort();
        test_random(0);
        test_random(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
